fetch_sequencer: RTL and testbench

- Instruction-fetch controller for the byte-organised instruction memory: 64 bytes, 16-bit big-endian instructions at even byte addresses, registered read with 1-cycle latency while read enable is high.
- Owns the program counter and issues one read at a time.
- Captures the returned word and presents it to decode over a valid/ready handshake.
- Handles branch redirects and halts on a sentinel instruction word.

---
 rtl/fetch_sequencer.sv | 137 +++++++++++++
 tb/tb_fetch_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one registered-memory read at a
// time, and hands each fetched word to decode over a valid/ready handshake.
module fetch_sequencer #(
    parameter int               WIDTH     = 16,
    parameter int               ADDR_W    = 6,
    parameter logic [WIDTH-1:0] HALT_WORD = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [WIDTH-1:0]  mem_data,
    output logic [WIDTH-1:0]  instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              halted,
    output logic [15:0]       instr_count,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_DELIVER = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(WIDTH / 8);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              halted_q, halted_d;
    logic [15:0]       instr_count_q, instr_count_d;
    logic [ADDR_W-1:0] redirect_tgt;

    // Handshake: a transfer happens on a rising edge where instr_valid and
    // instr_ready are both high; instr/instr_pc stay fixed while valid waits.
    assign redirect_tgt = {redirect_addr[ADDR_W-1:1], 1'b0};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        instr_count_d = instr_count_q;
        case (state_q)
            S_IDLE: begin
                if (redirect_valid) pc_d = redirect_tgt;
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (redirect_valid) pc_d = redirect_tgt;
                else state_d = S_WAIT;
            end
            S_WAIT: begin
                // A redirect discards the returning word without inspecting it.
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = S_FETCH;
                end else if (mem_data == HALT_WORD) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    instr_d       = mem_data;
                    instr_pc_d    = pc_q;
                    pc_d          = pc_q + PC_STEP;
                    instr_valid_d = 1'b1;
                    state_d       = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (instr_valid_q && instr_ready) begin
                    instr_valid_d = 1'b0;
                    instr_count_d = instr_count_q + 16'd1;
                    state_d       = S_FETCH;
                end
                if (redirect_valid) begin
                    pc_d          = redirect_tgt;
                    instr_valid_d = 1'b0;
                    state_d       = S_FETCH;
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    pc_d     = redirect_tgt;
                    halted_d = 1'b0;
                    state_d  = S_FETCH;
                end else if (start) begin
                    pc_d     = '0;
                    halted_d = 1'b0;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr    = pc_q;
    assign mem_rd_en   = (state_q == S_FETCH);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign instr_count = instr_count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: byte memory model, directed scenarios, and random
// fetch runs checked against an address-walk reference of expected deliveries.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_data = 16'h0;
    logic [15:0] instr;
    logic [5:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [5:0]  redirect_addr = 6'h0;
    logic        halted;
    logic [15:0] instr_count;
    logic [2:0]  state_dbg;

    logic [7:0]  mem [64];
    logic [21:0] exp_q[$];
    int total = 0;
    int bad = 0;

    fetch_sequencer dut (
        .clock(clock), .reset(reset), .start(start),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .halted(halted),
        .instr_count(instr_count), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    // Registered big-endian read, one cycle latency.
    always @(posedge clock) begin
        if (mem_rd_en) mem_data <= {mem[mem_addr], mem[mem_addr + 6'd1]};
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wr_word(input logic [5:0] a, input logic [15:0] w);
        mem[a]        = w[15:8];
        mem[a + 6'd1] = w[7:0];
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 8'h0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        start = 0; redirect_valid = 0; redirect_addr = 0; instr_ready = 0;
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (instr_valid) begin ok = 1; break; end
            step();
        end
    endtask

    task automatic wait_halted(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (halted) begin ok = 1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        clear_mem();
        do_reset();
        total++;
        if ({instr_valid, halted, mem_rd_en, instr_count, mem_addr, instr, instr_pc} !== 47'h0) begin
            bad++;
            $display("FAIL reset_state: valid=%b halted=%b rd=%b cnt=%0d addr=%0d instr=%h ipc=%0d, want all 0",
                     instr_valid, halted, mem_rd_en, instr_count, mem_addr, instr, instr_pc);
        end
    endtask

    task automatic test_basic();
        bit rd_seen;
        clear_mem();
        wr_word(0, 16'hFE21); wr_word(2, 16'hFB22); wr_word(4, 16'h0000);
        do_reset();
        instr_ready = 1;
        pulse_start();
        total++;
        if (!(mem_rd_en === 1'b1 && mem_addr === 6'd0)) begin
            bad++; $display("FAIL basic_first_read: rd=%b addr=%0d want rd=1 addr=0", mem_rd_en, mem_addr);
        end
        step();
        total++;
        if (instr_valid !== 1'b0) begin bad++; $display("FAIL basic_latency_early: valid=%b want 0", instr_valid); end
        step();
        total++;
        if (!(instr_valid === 1'b1 && instr === 16'hFE21 && instr_pc === 6'd0)) begin
            bad++; $display("FAIL basic_instr0: valid=%b instr=%h pc=%0d want 1 FE21 0", instr_valid, instr, instr_pc);
        end
        step(); step(); step();
        total++;
        if (!(instr_valid === 1'b1 && instr === 16'hFB22 && instr_pc === 6'd2)) begin
            bad++; $display("FAIL basic_instr1: valid=%b instr=%h pc=%0d want 1 FB22 2", instr_valid, instr, instr_pc);
        end
        step(); step(); step();
        total++;
        if (!(halted === 1'b1 && mem_addr === 6'd4 && instr_count === 16'd2 && instr_valid === 1'b0)) begin
            bad++; $display("FAIL basic_halt: halted=%b pc=%0d cnt=%0d valid=%b want 1 4 2 0",
                            halted, mem_addr, instr_count, instr_valid);
        end
        rd_seen = 0;
        for (int i = 0; i < 6; i++) begin step(); if (mem_rd_en) rd_seen = 1; end
        total++;
        if (rd_seen) begin bad++; $display("FAIL basic_no_read_in_halt: rd_en seen=1 want 0"); end
    endtask

    task automatic test_backpressure();
        bit ok, unstable;
        clear_mem();
        wr_word(0, 16'h1234); wr_word(2, 16'h5678);
        do_reset();
        pulse_start();
        wait_valid(10, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_timeout: valid=%b want 1", instr_valid); end
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!(instr_valid === 1'b1 && instr === 16'h1234 && instr_pc === 6'd0 && mem_rd_en === 1'b0))
                unstable = 1;
        end
        total++;
        if (unstable) begin
            bad++; $display("FAIL bp_hold: valid=%b instr=%h pc=%0d rd=%b want 1 1234 0 0", instr_valid, instr, instr_pc, mem_rd_en);
        end
        instr_ready = 1;
        step();
        total++;
        if (!(instr_count === 16'd1 && instr_valid === 1'b0 && mem_rd_en === 1'b1 && mem_addr === 6'd2)) begin
            bad++; $display("FAIL bp_release: cnt=%0d valid=%b rd=%b addr=%0d want 1 0 1 2",
                            instr_count, instr_valid, mem_rd_en, mem_addr);
        end
    endtask

    task automatic test_redirect_mid_read();
        bit ok;
        clear_mem();
        wr_word(0, 16'hAAAA); wr_word(6'h20, 16'hBBBB);
        do_reset();
        instr_ready = 1;
        pulse_start();
        step();
        redirect_valid = 1; redirect_addr = 6'h21;
        step();
        redirect_valid = 0; redirect_addr = 0;
        total++;
        if (!(mem_rd_en === 1'b1 && mem_addr === 6'h20 && instr_valid === 1'b0)) begin
            bad++; $display("FAIL redir_target: rd=%b addr=%h valid=%b want 1 20 0", mem_rd_en, mem_addr, instr_valid);
        end
        wait_valid(10, ok);
        total++;
        if (!(ok && instr === 16'hBBBB && instr_pc === 6'h20 && instr_count === 16'd0)) begin
            bad++; $display("FAIL redir_instr: ok=%b instr=%h pc=%h cnt=%0d want 1 BBBB 20 0", ok, instr, instr_pc, instr_count);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_mem();
        wr_word(62, 16'h1357); wr_word(0, 16'h2468);
        do_reset();
        redirect_valid = 1; redirect_addr = 6'd62; start = 1;
        step();
        redirect_valid = 0; start = 0;
        total++;
        if (!(mem_rd_en === 1'b1 && mem_addr === 6'd62)) begin
            bad++; $display("FAIL wrap_fetch62: rd=%b addr=%0d want 1 62", mem_rd_en, mem_addr);
        end
        wait_valid(10, ok);
        total++;
        if (!(ok && instr === 16'h1357 && instr_pc === 6'd62)) begin
            bad++; $display("FAIL wrap_instr: ok=%b instr=%h pc=%0d want 1 1357 62", ok, instr, instr_pc);
        end
        instr_ready = 1;
        step();
        total++;
        if (!(mem_rd_en === 1'b1 && mem_addr === 6'd0)) begin
            bad++; $display("FAIL wrap_next: rd=%b addr=%0d want 1 0", mem_rd_en, mem_addr);
        end
    endtask

    task automatic test_halt_restart();
        bit ok;
        clear_mem();
        wr_word(8, 16'h4321);
        do_reset();
        instr_ready = 1;
        pulse_start();
        wait_halted(10, ok);
        total++;
        if (!(ok && mem_addr === 6'd0)) begin bad++; $display("FAIL halt_enter: halted=%b pc=%0d want 1 0", halted, mem_addr); end
        pulse_start();
        total++;
        if (!(halted === 1'b0 && mem_rd_en === 1'b1 && mem_addr === 6'd0)) begin
            bad++; $display("FAIL halt_start: halted=%b rd=%b addr=%0d want 0 1 0", halted, mem_rd_en, mem_addr);
        end
        wait_halted(10, ok);
        redirect_valid = 1; redirect_addr = 6'd9; start = 1;
        step();
        redirect_valid = 0; start = 0;
        total++;
        if (!(ok && halted === 1'b0 && mem_rd_en === 1'b1 && mem_addr === 6'd8)) begin
            bad++; $display("FAIL halt_redirect: ok=%b halted=%b rd=%b addr=%0d want 1 0 1 8", ok, halted, mem_rd_en, mem_addr);
        end
        instr_ready = 0;
        wait_valid(10, ok);
        total++;
        if (!(ok && instr === 16'h4321 && instr_pc === 6'd8)) begin
            bad++; $display("FAIL halt_redirect_instr: ok=%b instr=%h pc=%0d want 1 4321 8", ok, instr, instr_pc);
        end
    endtask

    task automatic test_async_reset();
        bit ok, rd_seen;
        clear_mem();
        wr_word(0, 16'h1111); wr_word(2, 16'h2222);
        do_reset();
        instr_ready = 1;
        pulse_start();
        wait_valid(10, ok);
        step();
        instr_ready = 0;
        wait_valid(10, ok);
        total++;
        if (!(ok && instr_count === 16'd1)) begin bad++; $display("FAIL areset_setup: ok=%b cnt=%0d want 1 1", ok, instr_count); end
        #2 reset = 1;
        #1;
        total++;
        if (!(instr_valid === 1'b0 && halted === 1'b0 && instr_count === 16'd0 && mem_addr === 6'd0)) begin
            bad++; $display("FAIL areset_immediate: valid=%b halted=%b cnt=%0d addr=%0d want 0 0 0 0",
                            instr_valid, halted, instr_count, mem_addr);
        end
        @(negedge clock);
        reset = 0;
        rd_seen = 0;
        for (int i = 0; i < 6; i++) begin step(); if (mem_rd_en || instr_valid) rd_seen = 1; end
        total++;
        if (rd_seen) begin bad++; $display("FAIL areset_idle: fetch activity seen without start"); end
    endtask

    // Reference: from the start address, walk forward in 2-byte steps (mod 64)
    // delivering each word until the halt word; readiness only affects timing.
    task automatic test_random();
        logic [5:0]  s, a, halt_a;
        logic [21:0] got, e;
        int n, seen;
        bit done;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 64; i += 2) wr_word(6'(i), 16'($urandom_range(1, 16'hFFFF)));
            s = 6'($urandom_range(0, 31) * 2);
            n = $urandom_range(1, 20);
            halt_a = s + 6'(2 * n);
            wr_word(halt_a, 16'h0000);
            exp_q.delete();
            a = s;
            for (int k = 0; k < n; k++) begin
                exp_q.push_back({a, mem[a], mem[a + 6'd1]});
                a = a + 6'd2;
            end
            do_reset();
            redirect_valid = 1; redirect_addr = s | 6'($urandom_range(0, 1)); start = 1;
            step();
            redirect_valid = 0; start = 0;
            seen = 0; done = 0;
            for (int c = 0; c < 600 && !done; c++) begin
                instr_ready = 1'($urandom_range(0, 1));
                if (instr_valid && instr_ready) begin
                    got = {instr_pc, instr};
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3FFFFF;
                    seen++;
                    total++;
                    if (got !== e) begin
                        bad++; $display("FAIL rand_deliver: got pc=%0d instr=%h want pc=%0d instr=%h",
                                        got[21:16], got[15:0], e[21:16], e[15:0]);
                    end
                end
                step();
                if (halted) done = 1;
            end
            total++;
            if (!(done && exp_q.size() == 0 && instr_count === 16'(seen) && seen == n && mem_addr === halt_a)) begin
                bad++; $display("FAIL rand_end: halted=%b left=%0d cnt=%0d seen=%0d n=%0d pc=%0d want halt pc=%0d",
                                done, exp_q.size(), instr_count, seen, n, mem_addr, halt_a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_mid_read();
        test_wrap();
        test_halt_restart();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
